// File: rtl/pc_sequencer_if.sv
// Fetch request channel between the PC sequencer (master) and the I-cache (slave).
// The request is held stable while fetch_valid is high and fetch_ready is low.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             fetch_valid;
  logic             fetch_ready;
  logic [WIDTH-1:0] fetch_pc;

  modport master (
    output fetch_valid,
    output fetch_pc,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    output fetch_ready
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: sequential fetch-group advance, prioritised redirects
// (exception > ERET > branch), one-cycle fetch-queue flush, and a WAIT-driven halt state.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = 32'h0000_4180,
  parameter int               FETCH_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  pc_sequencer_if.master      fetch,
  input  logic                br_valid,
  input  logic [WIDTH-1:0]    br_target,
  input  logic                eret_valid,
  input  logic [WIDTH-1:0]    eret_target,
  input  logic                exc_valid,
  input  logic                halt_req,
  output logic                flush,
  output logic                misalign,
  output logic                halted
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(4 * FETCH_WIDTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH,
    S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic             halted_q, halted_d;

  logic             redirect;
  logic             redir_exc;
  logic [WIDTH-1:0] redir_tgt;
  logic             handshake;

  assign fetch.fetch_valid = fetch_valid_q;
  assign fetch.fetch_pc    = fetch_pc_q;
  assign flush             = flush_q;
  assign misalign          = misalign_q;
  assign halted            = halted_q;

  assign handshake = fetch_valid_q && fetch.fetch_ready;

  // Redirect arbitration; BOOT ignores everything and HALTED only listens to exceptions.
  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    redirect  = 1'b0;
    redir_exc = 1'b0;
    redir_tgt = '0;
    if (state_q != S_BOOT) begin
      if (exc_valid) begin
        redirect  = 1'b1;
        redir_exc = 1'b1;
        redir_tgt = EXC_VECTOR;
      end else if (state_q != S_HALTED && eret_valid) begin
        redirect  = 1'b1;
        redir_tgt = eret_target;
      end else if (state_q != S_HALTED && br_valid) begin
        redirect  = 1'b1;
        redir_tgt = br_target;
      end
    end
  end

  // State register and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      halted_q      <= halted_d;
    end
  end

  // Next-state logic; a redirect always beats a same-cycle halt request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN: begin
        if (redirect)      state_d = S_FLUSH;
        else if (halt_req) state_d = S_HALTED;
      end
      S_FLUSH:  state_d = redirect ? S_FLUSH : S_RUN;
      S_HALTED: if (redirect) state_d = S_FLUSH;
      default:  state_d = S_BOOT;
    endcase
  end

  // Output and PC datapath; outputs are the registered image of the next state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = (state_d == S_RUN);
    flush_d       = (state_d == S_FLUSH);
    halted_d      = (state_d == S_HALTED);
    misalign_d    = redirect && !redir_exc && (redir_tgt[1:0] != 2'b00);
    if (redirect) begin
      fetch_pc_d = {redir_tgt[WIDTH-1:2], 2'b00};
    end else if (state_q == S_RUN && handshake && !halt_req) begin
      fetch_pc_d = (fetch_pc_q & ALIGN_MASK) + STEP;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised self-checking bench for pc_sequencer against a behavioural fetch-PC model.
// Directed scenarios cover boot, stalls, redirect priority, misalignment, halt, wrap and async reset.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam int          GROUP      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, eret_valid, exc_valid, halt_req;
  logic [31:0] br_target, eret_target;
  logic        flush, misalign, halted;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.WIDTH(32)) fif ();

  pc_sequencer #(
    .WIDTH      (32),
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR),
    .FETCH_WIDTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (fif),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .eret_valid (eret_valid),
    .eret_target(eret_target),
    .exc_valid  (exc_valid),
    .halt_req   (halt_req),
    .flush      (flush),
    .misalign   (misalign),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: where fetch is, and which of the four observable modes it is in.
  logic [31:0] m_pc;
  bit          m_boot, m_valid, m_flush, m_halted, m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_boot   = 1'b1;
    m_valid  = 1'b0;
    m_flush  = 1'b0;
    m_halted = 1'b0;
    m_mis    = 1'b0;
  endtask

  task automatic model_clock();
    logic [31:0] tgt;
    bit          hit, is_exc;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
      return;
    end
    hit    = 1'b0;
    is_exc = 1'b0;
    tgt    = '0;
    if (exc_valid) begin
      hit = 1'b1; is_exc = 1'b1; tgt = EXC_VECTOR;
    end else if (!m_halted && eret_valid) begin
      hit = 1'b1; tgt = eret_target;
    end else if (!m_halted && br_valid) begin
      hit = 1'b1; tgt = br_target;
    end
    if (hit) begin
      m_pc     = tgt - (tgt % 4);
      m_flush  = 1'b1;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_mis    = !is_exc && (tgt % 4 != 0);
    end else begin
      m_mis = 1'b0;
      if (m_flush) begin
        m_flush = 1'b0;
        m_valid = 1'b1;
      end else if (!m_halted) begin
        if (halt_req) begin
          m_halted = 1'b1;
          m_valid  = 1'b0;
        end else if (fif.fetch_ready) begin
          m_pc = (m_pc / GROUP) * GROUP + GROUP;
        end
      end
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".fetch_pc"},    fif.fetch_pc,           m_pc);
    check({ctx, ".fetch_valid"}, 32'(fif.fetch_valid),   32'(m_valid));
    check({ctx, ".flush"},       32'(flush),             32'(m_flush));
    check({ctx, ".misalign"},    32'(misalign),          32'(m_mis));
    check({ctx, ".halted"},      32'(halted),            32'(m_halted));
  endtask

  task automatic set_in(input bit ready, input bit exc, input bit eret, input bit br,
                        input bit halt, input logic [31:0] et, input logic [31:0] bt);
    fif.fetch_ready = ready;
    exc_valid       = exc;
    eret_valid      = eret;
    br_valid        = br;
    halt_req        = halt;
    eret_target     = et;
    br_target       = bt;
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    model_clock();
    #1;
    check_all(ctx);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(7) == 0) t = {29'h1FFF_FFFF, 3'($urandom_range(7))};
    return t;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Boot, then sequential advance 0x3000 -> 0x3008.
    cycle("boot");
    check("boot.pc_lit", fif.fetch_pc, 32'h0000_3000);
    cycle("seq1");
    check("seq1.pc_lit", fif.fetch_pc, 32'h0000_3008);

    // Stall three cycles at 0x3008, then release.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle("stall");
    check("stall.pc_lit", fif.fetch_pc, 32'h0000_3008);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("release");
    check("release.pc_lit", fif.fetch_pc, 32'h0000_3010);

    // Branch redirect during a handshake.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h0000_3104);
    cycle("br");
    check("br.flush_lit", 32'(flush), 32'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("br_run");
    cycle("br_seq");
    check("br_seq.pc_lit", fif.fetch_pc, 32'h0000_3108);

    // All three redirects at once: exception wins.
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_5000, 32'h0000_6000);
    cycle("prio");
    check("prio.pc_lit", fif.fetch_pc, 32'h0000_4180);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("prio_run");

    // Misaligned branch target.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h0000_3106);
    cycle("mis");
    check("mis.pc_lit", fif.fetch_pc, 32'h0000_3104);
    check("mis.pulse_lit", 32'(misalign), 32'd1);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("mis_clear");

    // Halt, ignored branch, exception wake-up.
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    cycle("halt");
    check("halt.halted_lit", 32'(halted), 32'd1);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000);
    cycle("halt_ignore");
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("halt_exc");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("halt_wake");
    check("halt_wake.pc_lit", fif.fetch_pc, 32'h0000_4180);

    // Address wrap at the top of the space.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'hFFFF_FFF8);
    cycle("wrap_br");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle("wrap_run");
    cycle("wrap_seq");
    check("wrap.pc_lit", fif.fetch_pc, 32'h0000_0000);

    // Asynchronous reset while in FLUSH.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, 32'h0000_3200);
    cycle("pre_rst");
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    check("async_rst.pc_lit",    fif.fetch_pc, 32'h0000_3000);
    check("async_rst.flush_lit", 32'(flush),   32'd0);
    model_reset();
    cycle("rst_hold");
    rst = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(9) < 7,
             $urandom_range(19) == 0,
             $urandom_range(9) == 0,
             $urandom_range(6) == 0,
             $urandom_range(19) == 0,
             rand_target(), rand_target());
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
